vga_image_streamer: RTL

VGA_IMAGE_STREAMER -- requirements
Module: vga_image_streamer

---
 rtl/vga_stream_pkg.sv | 39 +++
 rtl/vga_image_streamer_if.sv | 13 +
 rtl/vga_image_rom.sv | 31 +++
 rtl/vga_image_streamer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/vga_stream_pkg.sv
// Shared types and helpers for the VGA image streamer: FSM state encoding,
// default resolution constants and colour-channel bit-replication expansion.
package vga_stream_pkg;

  typedef enum logic {
    ST_PRIME  = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  localparam int DEF_OUT_W       = 640;
  localparam int DEF_OUT_H       = 480;
  localparam int DEF_SCALE_SHIFT = 2;
  localparam int DEF_NUM_IMAGES  = 4;
  localparam int DEF_CH_BITS     = 4;
  localparam int DEF_OUT_CH_BITS = 10;
  localparam int MAX_CH_W        = 16;

  // Repeats the channel value MSB-first until out_bits are filled, so full
  // scale maps to full scale and zero stays zero.
  function automatic logic [MAX_CH_W-1:0] expand_ch(
    input logic [MAX_CH_W-1:0] c,
    input int                  ch_bits,
    input int                  out_bits
  );
    logic [MAX_CH_W-1:0] r;
    logic [3:0]          oi;
    logic [3:0]          ci;
    r = '0;
    for (int i = 0; i < MAX_CH_W; i++) begin
      if (i < out_bits) begin
        oi    = 4'(out_bits - 1 - i);
        ci    = 4'(ch_bits - 1 - (i % ch_bits));
        r[oi] = c[ci];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_image_streamer_if.sv
// Avalon-ST source bundle carrying the {R,G,B} pixel stream and packet framing.
interface vga_image_streamer_if #(
  parameter int DATA_W = 30
);
  logic [DATA_W-1:0] data;
  logic              startofpacket;
  logic              endofpacket;
  logic              valid;
  logic              ready;

  modport master (output data, startofpacket, endofpacket, valid, input ready);
  modport slave  (input data, startofpacket, endofpacket, valid, output ready);
endinterface

// File: rtl/vga_image_rom.sv
// One stored source image: a synchronous-read ROM with read enable whose
// contents are a fixed per-image pattern selected by IMAGE_ID.
module vga_image_rom
  import vga_stream_pkg::*;
#(
  parameter int DEPTH    = 19200,
  parameter int WIDTH    = 12,
  parameter int ADDR_W   = 15,
  parameter int IMAGE_ID = 0
) (
  input  logic              clk,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [WIDTH-1:0]  o_q
);

  logic [WIDTH-1:0] r_q;

  // Image 0 is a plain address ramp; the others are distinct affine patterns.
  function automatic logic [WIDTH-1:0] rom_word(input int unsigned a);
    if (a >= DEPTH) return '0;
    return WIDTH'(a * (2 * IMAGE_ID + 1) + IMAGE_ID * 32'h5A5);
  endfunction

  always_ff @(posedge clk) begin
    if (i_rd_en) r_q <= rom_word(32'(i_addr));
  end

  assign o_q = r_q;

endmodule

// File: rtl/vga_image_streamer.sv
// Streams an upscaled, optionally mirrored stored image as Avalon-ST frames,
// one pixel per clock under continuous ready, with per-frame image selection.
module vga_image_streamer
  import vga_stream_pkg::*;
#(
  parameter  int OUT_W       = DEF_OUT_W,
  parameter  int OUT_H       = DEF_OUT_H,
  parameter  int SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter  int NUM_IMAGES  = DEF_NUM_IMAGES,
  parameter  int CH_BITS     = DEF_CH_BITS,
  parameter  int OUT_CH_BITS = DEF_OUT_CH_BITS,
  localparam int SEL_W       = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] image_select,
  input  logic             mirror_en,
  output logic [15:0]      frame_count,
  vga_image_streamer_if.master st
);

  localparam int SRC_W  = OUT_W >> SCALE_SHIFT;
  localparam int SRC_H  = OUT_H >> SCALE_SHIFT;
  localparam int DEPTH  = SRC_W * SRC_H;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int X_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int Y_W    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int PIX_W  = 3 * CH_BITS;

  state_t           r_state;
  logic             r_armed;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [SEL_W-1:0] r_sel;
  logic             r_mirror;
  logic [15:0]      r_frame_cnt;

  logic             w_valid;
  logic             w_accept;
  logic             w_last_x;
  logic             w_last_y;
  logic             w_eop_acc;
  logic             w_prime_go;
  logic             w_rd_en;
  logic             w_rd_mirror;
  logic [X_W-1:0]   w_nx;
  logic [Y_W-1:0]   w_ny;
  logic [X_W-1:0]   w_ax;
  logic [Y_W-1:0]   w_ay;
  logic [ADDR_W-1:0] w_sx;
  logic [ADDR_W-1:0] w_addr;
  logic [PIX_W-1:0] w_rom_q [NUM_IMAGES];
  logic [PIX_W-1:0] w_pix;
  logic [OUT_CH_BITS-1:0] w_r;
  logic [OUT_CH_BITS-1:0] w_g;
  logic [OUT_CH_BITS-1:0] w_b;

  assign w_valid    = (r_state == ST_STREAM);
  assign w_accept   = w_valid & st.ready;
  assign w_last_x   = (r_x == X_W'(OUT_W - 1));
  assign w_last_y   = (r_y == Y_W'(OUT_H - 1));
  assign w_eop_acc  = w_accept & w_last_x & w_last_y;
  // The first edge after reset release only arms PRIME, so PRIME always
  // spans one full clock and valid rises on the second edge.
  assign w_prime_go = (r_state == ST_PRIME) & r_armed;
  assign w_rd_en    = w_prime_go | w_accept;
  // The read for a new frame's first pixel must already use the mirror
  // setting that is being latched on this same edge.
  assign w_rd_mirror = (w_prime_go | w_eop_acc) ? mirror_en : r_mirror;

  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    if (w_last_x) begin
      w_nx = '0;
      w_ny = w_last_y ? '0 : r_y + 1'b1;
    end else begin
      w_nx = r_x + 1'b1;
    end
  end

  assign w_ax = (r_state == ST_PRIME) ? '0 : w_nx;
  assign w_ay = (r_state == ST_PRIME) ? '0 : w_ny;

  always_comb begin
    w_sx = ADDR_W'(w_ax >> SCALE_SHIFT);
    if (w_rd_mirror) w_sx = ADDR_W'(SRC_W - 1) - w_sx;
    w_addr = ADDR_W'(w_ay >> SCALE_SHIFT) * ADDR_W'(SRC_W) + w_sx;
  end

  for (genvar gi = 0; gi < NUM_IMAGES; gi++) begin : g_rom
    vga_image_rom #(
      .DEPTH   (DEPTH),
      .WIDTH   (PIX_W),
      .ADDR_W  (ADDR_W),
      .IMAGE_ID(gi)
    ) u_rom (
      .clk    (clk),
      .i_rd_en(w_rd_en),
      .i_addr (w_addr),
      .o_q    (w_rom_q[gi])
    );
  end

  // An out-of-range selection matches no ROM and leaves the pixel at zero.
  always_comb begin
    w_pix = '0;
    for (int i = 0; i < NUM_IMAGES; i++) begin
      if (r_sel == SEL_W'(i)) w_pix = w_rom_q[i];
    end
  end

  assign w_r = OUT_CH_BITS'(expand_ch(MAX_CH_W'(w_pix[3*CH_BITS-1 -: CH_BITS]), CH_BITS, OUT_CH_BITS));
  assign w_g = OUT_CH_BITS'(expand_ch(MAX_CH_W'(w_pix[2*CH_BITS-1 -: CH_BITS]), CH_BITS, OUT_CH_BITS));
  assign w_b = OUT_CH_BITS'(expand_ch(MAX_CH_W'(w_pix[CH_BITS-1 -: CH_BITS]), CH_BITS, OUT_CH_BITS));

  assign st.valid         = w_valid;
  assign st.data          = w_valid ? {w_r, w_g, w_b} : '0;
  assign st.startofpacket = w_valid & (r_x == '0) & (r_y == '0);
  assign st.endofpacket   = w_valid & w_last_x & w_last_y;
  assign frame_count      = r_frame_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_PRIME;
      r_armed     <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_sel       <= '0;
      r_mirror    <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        ST_PRIME: begin
          if (r_armed) begin
            r_state  <= ST_STREAM;
            r_sel    <= image_select;
            r_mirror <= mirror_en;
          end
        end
        ST_STREAM: begin
          if (w_accept) begin
            r_x <= w_nx;
            r_y <= w_ny;
            if (w_eop_acc) begin
              r_sel       <= image_select;
              r_mirror    <= mirror_en;
              r_frame_cnt <= r_frame_cnt + 16'd1;
            end
          end
        end
        default: r_state <= ST_PRIME;
      endcase
    end
  end

endmodule
